// File: rtl/pkt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_pkg                                                              |
// | Shared types and constants for the packet copy buffer read side.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DROP    = 3'd3,
        ST_GAP     = 3'd4
    } pkt_state_t;

    localparam int c_HDR_WORDS       = 2;
    localparam int c_MAX_LEN_DEFAULT = 1518;
    localparam int c_GAP_DEFAULT     = 2;

    // Gap counter only has to count 0..gap-1; keep at least one bit.
    function automatic int gap_cnt_width(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_fifo_reader                                                      |
// | Drains length-prefixed packets from a FWFT FIFO into a valid/ready   |
// | word stream with sop/eop markers; bad length headers are dropped.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pkt_fifo_reader
    import pkt_pkg::*;
#(
    parameter int pBITS    = 8,
    parameter int pMAX_LEN = c_MAX_LEN_DEFAULT,
    parameter int pGAP     = c_GAP_DEFAULT
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ififo_empty,
    input  logic [pBITS-1:0] ififo_data,
    output logic             ofifo_rd,
    output logic [pBITS-1:0] odata,
    output logic             ovalid,
    output logic             osop,
    output logic             oeop,
    input  logic             iready,
    output logic             oerr,
    output logic             obusy,
    output logic [15:0]      opkt_cnt
);

    localparam int                 c_LEN_W    = c_HDR_WORDS * pBITS;
    localparam int                 c_GAP_W    = gap_cnt_width(pGAP);
    localparam int                 c_GAP_LAST = (pGAP > 0) ? pGAP - 1 : 0;
    localparam logic [c_LEN_W-1:0] c_MAX_LEN  = c_LEN_W'(pMAX_LEN);
    localparam logic [c_LEN_W-1:0] c_ONE      = c_LEN_W'(1);
    localparam pkt_state_t         c_AFTER    = (pGAP == 0) ? ST_IDLE : ST_GAP;

    pkt_state_t         state_q;
    logic [pBITS-1:0]   len_hi_q;
    logic [c_LEN_W-1:0] remaining_q;
    logic               first_q;
    logic [c_GAP_W-1:0] gap_cnt_q;
    logic [pBITS-1:0]   odata_q;
    logic               ovalid_q;
    logic               osop_q;
    logic               oeop_q;
    logic               oerr_q;
    logic [15:0]        pkt_cnt_q;

    logic               fifo_pop;
    logic               out_free;
    logic               accept;
    logic               last_word;
    logic [c_LEN_W-1:0] len_d;
    logic [c_LEN_W-1:0] remaining_d;
    logic [15:0]        pkt_cnt_d;

    assign accept      = ovalid_q & iready;
    assign out_free    = ~ovalid_q | iready;
    assign last_word   = (remaining_q == c_ONE);
    assign len_d       = {len_hi_q, ififo_data};
    assign remaining_d = (remaining_q != '0) ? remaining_q - c_ONE : remaining_q;
    assign pkt_cnt_d   = pkt_cnt_q + 16'd1;

    // Pop is combinational so a FWFT head word is consumed in the same cycle it is used.
    always_comb begin
        fifo_pop = 1'b0;
        if (!ireset && !ififo_empty) begin
            case (state_q)
                ST_IDLE, ST_LEN_LO, ST_DROP: fifo_pop = 1'b1;
                ST_PAYLOAD:                  fifo_pop = out_free;
                default:                     fifo_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            gap_cnt_q   <= '0;
            odata_q     <= '0;
            ovalid_q    <= 1'b0;
            osop_q      <= 1'b0;
            oeop_q      <= 1'b0;
            oerr_q      <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            oerr_q <= 1'b0;

            if (accept) begin
                ovalid_q <= 1'b0;
                osop_q   <= 1'b0;
                oeop_q   <= 1'b0;
                if (oeop_q) begin
                    pkt_cnt_q <= pkt_cnt_d;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        len_hi_q <= ififo_data;
                        state_q  <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (fifo_pop) begin
                        if (len_d == '0) begin
                            oerr_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (len_d > c_MAX_LEN) begin
                            oerr_q      <= 1'b1;
                            remaining_q <= len_d;
                            state_q     <= ST_DROP;
                        end else begin
                            remaining_q <= len_d;
                            first_q     <= 1'b1;
                            state_q     <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    // A reload here overrides the clear from a same-cycle accept.
                    if (fifo_pop) begin
                        odata_q     <= ififo_data;
                        ovalid_q    <= 1'b1;
                        osop_q      <= first_q;
                        oeop_q      <= last_word;
                        first_q     <= 1'b0;
                        remaining_q <= remaining_d;
                        if (last_word) begin
                            gap_cnt_q <= '0;
                            state_q   <= c_AFTER;
                        end
                    end
                end

                ST_DROP: begin
                    if (fifo_pop) begin
                        remaining_q <= remaining_d;
                        if (last_word) begin
                            gap_cnt_q <= '0;
                            state_q   <= c_AFTER;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q == c_GAP_W'(c_GAP_LAST)) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + c_GAP_W'(1);
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ofifo_rd = fifo_pop;
    assign odata    = odata_q;
    assign ovalid   = ovalid_q;
    assign osop     = osop_q;
    assign oeop     = oeop_q;
    assign oerr     = oerr_q;
    assign obusy    = (state_q != ST_IDLE) | ovalid_q;
    assign opkt_cnt = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pkt_fifo_reader                                                   |
// | Directed self-checking bench with a FWFT FIFO model and scoreboard.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pkt_fifo_reader;

    localparam int c_GAP = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic        iclk        = 1'b0;
    logic        ireset      = 1'b1;
    logic        ififo_empty = 1'b1;
    logic [7:0]  ififo_data  = 8'h00;
    logic        iready      = 1'b0;
    logic        ofifo_rd;
    logic [7:0]  odata;
    logic        ovalid;
    logic        osop;
    logic        oeop;
    logic        oerr;
    logic        obusy;
    logic [15:0] opkt_cnt;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] fifo_q[$];
    logic       hold_empty = 1'b0;
    int         pop_cyc_q[$];
    beat_t      exp_q[$];
    int         err_pulses    = 0;
    int         err_cyc       = -1;
    int         valid_cycles  = 0;
    int         first_vld_cyc = -1;
    int         extra_beats   = 0;
    int         rd_empty_viol = 0;
    logic       stall_prev    = 1'b0;
    beat_t      stall_beat    = '0;
    logic       rd_s;
    int         cyc_s;

    pkt_fifo_reader #(
        .pBITS    (8),
        .pMAX_LEN (1518),
        .pGAP     (c_GAP)
    ) dut (
        .iclk        (iclk),
        .ireset      (ireset),
        .ififo_empty (ififo_empty),
        .ififo_data  (ififo_data),
        .ofifo_rd    (ofifo_rd),
        .odata       (odata),
        .ovalid      (ovalid),
        .osop        (osop),
        .oeop        (oeop),
        .iready      (iready),
        .oerr        (oerr),
        .obusy       (obusy),
        .opkt_cnt    (opkt_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO model sharing the DUT reset; a pop is applied just after the edge.
    always @(posedge iclk) begin
        rd_s  = ofifo_rd;
        cyc_s = cyc;
        cyc   = cyc + 1;
        #1;
        if (ireset) begin
            fifo_q.delete();
        end else if (rd_s) begin
            if (ififo_empty) begin
                rd_empty_viol++;
            end else begin
                void'(fifo_q.pop_front());
                pop_cyc_q.push_back(cyc_s);
            end
        end
        ififo_empty = hold_empty || (fifo_q.size() == 0);
        ififo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Output monitor and scoreboard.
    always @(negedge iclk) begin
        #2;
        if (!ireset) begin
            if (oerr) begin
                err_pulses++;
                err_cyc = cyc;
            end
            if (ovalid) begin
                valid_cycles++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (stall_prev) chk("hold_stable", {ovalid, odata, osop, oeop}, {1'b1, stall_beat});
            if (ovalid && iready) begin
                if (exp_q.size() == 0) extra_beats++;
                else chk("beat", {odata, osop, oeop}, exp_q.pop_front());
            end
            stall_prev = ovalid && !iready;
            stall_beat = {odata, osop, oeop};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_hdr(input logic [15:0] len);
        fifo_q.push_back(len[15:8]);
        fifo_q.push_back(len[7:0]);
    endtask

    task automatic push_word(input logic [7:0] w, input logic sop, input logic eop);
        fifo_q.push_back(w);
        exp_q.push_back({w, sop, eop});
    endtask

    task automatic clear_stats();
        pop_cyc_q.delete();
        err_pulses    = 0;
        err_cyc       = -1;
        valid_cycles  = 0;
        first_vld_cyc = -1;
        extra_beats   = 0;
    endtask

    task automatic drain(input string tag, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge iclk);
            done = (exp_q.size() == 0) && (fifo_q.size() == 0) && !obusy;
        end
        repeat (2) @(negedge iclk);
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ireset = 1'b1;
        iready = 1'b0;
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        #1;
        chk("reset_ctrl", {ofifo_rd, ovalid, osop, oeop, oerr, obusy}, 32'd0);
        chk("reset_data", odata, 32'd0);
        chk("reset_cnt", opkt_cnt, 32'd0);

        // 3-word packet back to back with a 1-word packet; timing and gap.
        @(negedge iclk);
        iready = 1'b1;
        clear_stats();
        push_hdr(16'h0003);
        push_word(8'hA1, 1'b1, 1'b0);
        push_word(8'hA2, 1'b0, 1'b0);
        push_word(8'hA3, 1'b0, 1'b1);
        push_hdr(16'h0001);
        push_word(8'hD1, 1'b1, 1'b1);
        drain("t2_drain", 100);
        chk("t2_pops", pop_cyc_q.size(), 32'd8);
        if (pop_cyc_q.size() == 8) begin
            chk("t2_hdr_spacing", pop_cyc_q[1] - pop_cyc_q[0], 32'd1);
            chk("t2_throughput", pop_cyc_q[4] - pop_cyc_q[0], 32'd4);
            chk("t2_latency", first_vld_cyc - pop_cyc_q[0], 32'd3);
            chk("t2_gap", pop_cyc_q[5] - pop_cyc_q[4], c_GAP + 1);
        end
        chk("t2_valid_cycles", valid_cycles, 32'd4);
        chk("t2_err", err_pulses, 32'd0);
        chk("t2_extra", extra_beats, 32'd0);
        chk("t2_cnt", opkt_cnt, 32'd2);

        // Same packet with iready toggling and a 2-cycle FIFO underrun.
        clear_stats();
        push_hdr(16'h0003);
        push_word(8'hA1, 1'b1, 1'b0);
        push_word(8'hA2, 1'b0, 1'b0);
        push_word(8'hA3, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            iready     = ~iready;
            hold_empty = (i == 4) || (i == 5);
        end
        hold_empty = 1'b0;
        iready     = 1'b1;
        drain("t3_drain", 50);
        chk("t3_pops", pop_cyc_q.size(), 32'd5);
        chk("t3_extra", extra_beats, 32'd0);
        chk("t3_cnt", opkt_cnt, 32'd3);

        // Zero-length header, then a 1-word packet.
        clear_stats();
        push_hdr(16'h0000);
        push_hdr(16'h0001);
        push_word(8'hB1, 1'b1, 1'b1);
        drain("t4_drain", 60);
        chk("t4_err_pulses", err_pulses, 32'd1);
        if (pop_cyc_q.size() >= 2) chk("t4_err_timing", err_cyc - pop_cyc_q[1], 32'd1);
        chk("t4_valid_cycles", valid_cycles, 32'd1);
        chk("t4_extra", extra_beats, 32'd0);
        chk("t4_cnt", opkt_cnt, 32'd4);

        // Oversize header (1519) is dropped, then a 2-word packet.
        clear_stats();
        push_hdr(16'h05EF);
        for (int i = 0; i < 1519; i++) fifo_q.push_back(8'(i));
        push_hdr(16'h0002);
        push_word(8'hC1, 1'b1, 1'b0);
        push_word(8'hC2, 1'b0, 1'b1);
        drain("t5_drain", 3000);
        chk("t5_err_pulses", err_pulses, 32'd1);
        if (pop_cyc_q.size() >= 2) chk("t5_err_timing", err_cyc - pop_cyc_q[1], 32'd1);
        chk("t5_pops", pop_cyc_q.size(), 32'd1525);
        chk("t5_valid_cycles", valid_cycles, 32'd2);
        chk("t5_extra", extra_beats, 32'd0);
        chk("t5_cnt", opkt_cnt, 32'd5);

        // Reset with a packet in flight and the output register stalled.
        clear_stats();
        iready = 1'b0;
        push_hdr(16'h0005);
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hE0 + 8'(i));
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge iclk);
                seen = ovalid;
            end
            chk("rst_inflight", {31'd0, seen}, 32'd1);
        end
        @(negedge iclk);
        ireset = 1'b1;
        #1;
        chk("rst_ctrl", {ofifo_rd, ovalid, osop, oeop, oerr, obusy}, 32'd0);
        chk("rst_data", odata, 32'd0);
        chk("rst_cnt", opkt_cnt, 32'd0);
        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        iready = 1'b1;
        repeat (8) @(negedge iclk);
        chk("rst_idle", {obusy, ovalid}, 32'd0);
        chk("rst_extra", extra_beats, 32'd0);

        // Counter wrap: preload 0xFFFF, one more packet returns it to 0.
        clear_stats();
        @(negedge iclk);
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge iclk);
        release dut.pkt_cnt_q;
        #1;
        chk("wrap_preload", opkt_cnt, 32'h0000FFFF);
        push_hdr(16'h0001);
        push_word(8'hF1, 1'b1, 1'b1);
        drain("wrap_drain", 60);
        chk("wrap_cnt", opkt_cnt, 32'd0);
        chk("wrap_extra", extra_beats, 32'd0);

        chk("rd_when_empty", rd_empty_viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
